// File: rtl/bib_yanitlayici_pkg.sv
// Shared definitions for the bus responder: FSM states, address regions and the region decoder.
package bib_yanitlayici_pkg;

  // Responder FSM states.
  typedef enum logic [1:0] {
    BOSTA       = 2'd0,
    BELLEK_OKU  = 2'd1,
    CEVRE_BEKLE = 2'd2,
    YANIT       = 2'd3
  } durum_t;

  // Decoded target region of a bus access.
  typedef enum logic [1:0] {
    BOLGE_HATA   = 2'd0,
    BOLGE_BELLEK = 2'd1,
    BOLGE_CEVRE  = 2'd2
  } bolge_t;

  // Upper address nibble that selects each region.
  localparam logic [3:0] BOLGE_BELLEK_KODU = 4'h4;
  localparam logic [3:0] BOLGE_CEVRE_KODU  = 4'h2;

  // Timeout counter width; the wait limit saturates at its maximum.
  localparam int unsigned SAYAC_BIT = 8;

  // Map the top address nibble to a region; anything unmapped is a bus error.
  function automatic bolge_t bolge_coz(input logic [3:0] ust_nibble);
    bolge_t sonuc;
    sonuc = BOLGE_HATA;
    if (ust_nibble == BOLGE_BELLEK_KODU) begin
      sonuc = BOLGE_BELLEK;
    end else if (ust_nibble == BOLGE_CEVRE_KODU) begin
      sonuc = BOLGE_CEVRE;
    end
    return sonuc;
  endfunction

endpackage

// File: rtl/bib_yanitlayici_zaman_asimi_sayaci.sv
// Peripheral wait counter: counts cycles while enabled and flags the last allowed wait cycle.
module zaman_asimi_sayaci
  import bib_yanitlayici_pkg::*;
#(
  parameter int unsigned ZAMAN_ASIMI = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic say_i,
  output logic doldu_o
);

  // Clamp the limit into the counter range; a limit of 0 behaves like 1.
  localparam int unsigned SINIR = (ZAMAN_ASIMI > 255) ? 255 :
                                  ((ZAMAN_ASIMI == 0) ? 1 : ZAMAN_ASIMI);
  localparam logic [SAYAC_BIT-1:0] SON = SAYAC_BIT'(SINIR - 1);

  logic [SAYAC_BIT-1:0] sayac_q;

  // Count wait cycles; cleared whenever the responder is not waiting.
  always_ff @(posedge clk_i) begin
    if (rst_i || !say_i) begin
      sayac_q <= '0;
    end else if (sayac_q != {SAYAC_BIT{1'b1}}) begin
      sayac_q <= sayac_q + 1'b1;
    end
  end

  // High in the final wait cycle, so the FSM can leave on the following edge.
  always_comb begin
    doldu_o = say_i && (sayac_q == SON);
  end

endmodule

// File: rtl/bib_yanitlayici.sv
// Bus responder: routes master accesses to on-chip SRAM or a peripheral port, or flags a bus error.
module bib_yanitlayici
  import bib_yanitlayici_pkg::*;
#(
  parameter int unsigned BELLEK_ADR_BIT = 16,
  parameter int unsigned ZAMAN_ASIMI    = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      bib_sec_i,
  input  logic [31:0]               bib_adr_i,
  input  logic [31:0]               bib_veri_i,
  input  logic [3:0]                bib_veri_maske_i,
  output logic [31:0]               bib_veri_o,
  output logic                      bib_durdur_o,
  output logic                      bram_en_o,
  output logic [3:0]                bram_yaz_maske_o,
  output logic [BELLEK_ADR_BIT-1:0] bram_adr_o,
  output logic [31:0]               bram_veri_o,
  input  logic [31:0]               bram_veri_i,
  output logic                      cevre_gecerli_o,
  output logic [31:0]               cevre_adr_o,
  output logic [31:0]               cevre_veri_o,
  output logic [3:0]                cevre_maske_o,
  input  logic                      cevre_hazir_i,
  input  logic [31:0]               cevre_veri_i,
  output logic                      hata_o
);

  durum_t      durum_q, durum_d;
  logic [31:0] yanit_q, yanit_d;     // response being prepared for the current access
  logic [31:0] son_q;                // last response actually delivered to the master
  logic        hata_q, hata_d;
  logic        iptal_q, iptal_d;     // master gave up on the in-flight peripheral access
  logic [31:0] cevre_adr_q, cevre_adr_d;
  logic [31:0] cevre_veri_q, cevre_veri_d;
  logic [3:0]  cevre_maske_q, cevre_maske_d;

  logic        bram_en;
  logic [3:0]  bram_maske;
  logic        tamam;
  logic        doldu;
  logic        iptal;
  bolge_t      bolge;
  logic        unused_adr;

  assign bolge = bolge_coz(bib_adr_i[31:28]);
  assign tamam = (durum_q == YANIT) && bib_sec_i;
  assign iptal = iptal_q || !bib_sec_i;
  // Byte-lane bits and out-of-window bits are intentionally ignored.
  assign unused_adr = ^bib_adr_i;

  zaman_asimi_sayaci #(
    .ZAMAN_ASIMI(ZAMAN_ASIMI)
  ) u_zaman_asimi_sayaci (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .say_i  (durum_q == CEVRE_BEKLE),
    .doldu_o(doldu)
  );

  // Next-state, response capture and SRAM strobes.
  always_comb begin
    durum_d       = durum_q;
    yanit_d       = yanit_q;
    hata_d        = 1'b0;
    iptal_d       = iptal_q;
    cevre_adr_d   = cevre_adr_q;
    cevre_veri_d  = cevre_veri_q;
    cevre_maske_d = cevre_maske_q;
    bram_en       = 1'b0;
    bram_maske    = 4'b0000;

    unique case (durum_q)
      BOSTA: begin
        iptal_d = 1'b0;
        if (bib_sec_i) begin
          case (bolge)
            BOLGE_BELLEK: begin
              bram_en = 1'b1;
              if (bib_veri_maske_i != 4'b0000) begin
                bram_maske = bib_veri_maske_i;
                yanit_d    = '0;
                durum_d    = YANIT;
              end else begin
                durum_d = BELLEK_OKU;
              end
            end
            BOLGE_CEVRE: begin
              cevre_adr_d   = bib_adr_i;
              cevre_veri_d  = bib_veri_i;
              cevre_maske_d = bib_veri_maske_i;
              durum_d       = CEVRE_BEKLE;
            end
            default: begin
              // Error region: no side effects, zero data, one error pulse.
              yanit_d = '0;
              hata_d  = 1'b1;
              durum_d = YANIT;
            end
          endcase
        end
      end

      BELLEK_OKU: begin
        // The SRAM read has completed either way; only keep it if the master still waits.
        if (bib_sec_i) begin
          yanit_d = bram_veri_i;
          durum_d = YANIT;
        end else begin
          durum_d = BOSTA;
        end
      end

      CEVRE_BEKLE: begin
        if (!bib_sec_i) begin
          iptal_d = 1'b1;
        end
        if (cevre_hazir_i) begin
          if (iptal) begin
            iptal_d = 1'b0;
            durum_d = BOSTA;
          end else begin
            yanit_d = (cevre_maske_q == 4'b0000) ? cevre_veri_i : '0;
            durum_d = YANIT;
          end
        end else if (doldu) begin
          if (iptal) begin
            iptal_d = 1'b0;
            durum_d = BOSTA;
          end else begin
            yanit_d = '0;
            hata_d  = 1'b1;
            durum_d = YANIT;
          end
        end
      end

      YANIT: begin
        // Either the completion cycle or an abandoned response; both end the access.
        durum_d = BOSTA;
      end

      default: begin
        durum_d = BOSTA;
      end
    endcase
  end

  // State and response registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_q       <= BOSTA;
      yanit_q       <= '0;
      son_q         <= '0;
      hata_q        <= 1'b0;
      iptal_q       <= 1'b0;
      cevre_adr_q   <= '0;
      cevre_veri_q  <= '0;
      cevre_maske_q <= '0;
    end else begin
      durum_q       <= durum_d;
      yanit_q       <= yanit_d;
      hata_q        <= hata_d;
      iptal_q       <= iptal_d;
      cevre_adr_q   <= cevre_adr_d;
      cevre_veri_q  <= cevre_veri_d;
      cevre_maske_q <= cevre_maske_d;
      if (tamam) begin
        son_q <= yanit_q;
      end
    end
  end

  // Output drive; SRAM strobes are combinational and suppressed while in reset.
  always_comb begin
    bib_veri_o       = tamam ? yanit_q : son_q;
    bib_durdur_o     = bib_sec_i && (rst_i || (durum_q != YANIT));
    bram_en_o        = bram_en && !rst_i;
    bram_yaz_maske_o = rst_i ? 4'b0000 : bram_maske;
    bram_adr_o       = bib_adr_i[BELLEK_ADR_BIT+1:2];
    bram_veri_o      = bib_veri_i;
    cevre_gecerli_o  = (durum_q == CEVRE_BEKLE);
    cevre_adr_o      = cevre_adr_q;
    cevre_veri_o     = cevre_veri_q;
    cevre_maske_o    = cevre_maske_q;
    hata_o           = hata_q;
  end

endmodule

// File: doc/bib_yanitlayici.md
BIB_YANITLAYICI -- requirements
Module: bib_yanitlayici

Interface
REQ-001 SHALL have parameter BELLEK_ADR_BIT, default 16: SRAM word-address width (256 KiB).
REQ-002 SHALL have parameter ZAMAN_ASIMI, default 255: peripheral wait limit in cycles (max 255).
REQ-003 SHALL use one clock and a synchronous, active-high reset: clk_i, rst_i.
REQ-004 SHALL have these ports (name, direction, width, meaning):
- clk_i in 1: clock.
- rst_i in 1: synchronous active-high reset.
- bib_sec_i in 1: request present.
- bib_adr_i in 32: byte address.
- bib_veri_i in 32: write data.
- bib_veri_maske_i in 4: byte enables; 0 = read.
- bib_veri_o out 32: read data.
- bib_durdur_o out 1: stall to master.
- bram_en_o out 1: SRAM port enable.
- bram_yaz_maske_o out 4: SRAM byte write enables.
- bram_adr_o out BELLEK_ADR_BIT: SRAM word address.
- bram_veri_o out 32: SRAM write data.
- bram_veri_i in 32: SRAM read data, valid 1 cycle after enable.
- cevre_gecerli_o out 1: peripheral request valid.
- cevre_adr_o out 32: peripheral address.
- cevre_veri_o out 32: peripheral write data.
- cevre_maske_o out 4: peripheral byte enables.
- cevre_hazir_i in 1: peripheral done.
- cevre_veri_i in 32: peripheral read data, valid with cevre_hazir_i.
- hata_o out 1: one-cycle bus-error pulse.

Function
REQ-005 SHALL decode the region: bib_adr_i[31:28]==4'h4 is SRAM, bram_adr_o = bib_adr_i[BELLEK_ADR_BIT+1:2]; bib_adr_i[31:28]==4'h2 is peripheral; all other addresses are error.
REQ-006 SHALL implement FSM states BOSTA, BELLEK_OKU, CEVRE_BEKLE, YANIT.
REQ-007 SHALL, in BOSTA with bib_sec_i=1:
- SRAM read: assert bram_en_o, go to BELLEK_OKU.
- SRAM write: assert bram_en_o with bram_yaz_maske_o=mask, go to YANIT.
- Peripheral: register adr/data/mask, go to CEVRE_BEKLE.
- Error: go to YANIT with response data 0.
REQ-008 SHALL, in BELLEK_OKU, capture bram_veri_i into the response register and go to YANIT.
REQ-009 SHALL, in CEVRE_BEKLE, hold cevre_gecerli_o=1 with stable registered fields until cevre_hazir_i=1, capturing cevre_veri_i on reads, then go to YANIT.
REQ-010 SHALL count CEVRE_BEKLE cycles with an 8-bit counter; on reaching ZAMAN_ASIMI without cevre_hazir_i, drop cevre_gecerli_o, set response data 0, pulse hata_o, and go to YANIT.
REQ-011 SHALL pulse hata_o for exactly one cycle on entering YANIT from an error-region access.
REQ-012 SHALL drive bib_durdur_o = bib_sec_i AND (state != YANIT), combinationally.
REQ-013 SHALL define the completion cycle as YANIT with bib_sec_i=1: bib_veri_o is valid and the next state is BOSTA.
REQ-014 SHALL give latencies as stall cycles before completion: SRAM read 2; SRAM write 1; error 1; peripheral = cycles to cevre_hazir_i + 1.
REQ-015 SHALL accept a back-to-back request in the cycle after completion without extra idle cycles.
REQ-016 SHALL handle bib_sec_i=0 in a busy state (abort) as follows: the in-flight SRAM or peripheral transaction finishes internally, its result is discarded, and the FSM returns to BOSTA; requests arriving meanwhile stall until BOSTA.
REQ-017 SHALL make writes to the error region have no side effects.
REQ-018 SHALL ignore bib_adr_i[1:0] and return full 32-bit words; the master performs byte and halfword extraction.
REQ-019 SHALL hold bib_veri_o at its last response value outside completion cycles.

Reset
REQ-020 SHALL, when rst_i=1 at a clock edge, go to BOSTA, clear the counter, and zero bib_veri_o, hata_o, cevre_gecerli_o, bram_en_o and bram_yaz_maske_o, including when reset occurs mid-transaction.
REQ-021 SHALL keep bib_durdur_o=1 during reset whenever bib_sec_i=1.

Structure
REQ-022 SHALL place FSM state encodings and region constants (4'h4, 4'h2) in the shared tanimlamalar.vh.
REQ-023 SHALL implement the timeout counter as the one natural sub-module, zaman_asimi_sayaci; everything else stays flat.

Verification
REQ-024 SHALL cover an SRAM write then read:
- Stimulus: write 0x4000_0010, mask 4'b1111, data 0xDEADBEEF; then read the same address.
- Response: write stalls 1 cycle; read stalls 2 cycles and returns 0xDEADBEEF.
REQ-025 SHALL cover byte-enable writes:
- Stimulus: write 0x4000_0010, mask 4'b0010, data 0x0000AA00.
- Response: a subsequent read returns 0xDEADAAEF.
REQ-026 SHALL cover a peripheral read:
- Stimulus: read 0x2000_0004; cevre_hazir_i rises 3 cycles later with 0x12345678.
- Response: stall is 4 cycles, bib_veri_o=0x12345678, hata_o stays 0.
REQ-027 SHALL cover peripheral timeout:
- Stimulus: read 0x2000_0008, cevre_hazir_i held 0.
- Response: after 255 wait cycles, response data is 0 and hata_o pulses once.
REQ-028 SHALL cover an error-region access:
- Stimulus: write 0x1000_0000.
- Response: 1 stall cycle, hata_o pulse, no SRAM or peripheral activity.
REQ-029 SHALL cover reset and abort:
- Stimulus: rst_i asserted in BELLEK_OKU; separately, bib_sec_i dropped in CEVRE_BEKLE.
- Response: on reset, all outputs are zero the next cycle; on abort, the FSM returns to BOSTA after cevre_hazir_i with no hata_o.
